// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
//   Shared types and constants for the I2S transmit sample FIFO.
//   fifo_state_t   : serving state of the FIFO (idle / priming / running)
//   I2S_WORD_W     : width of the word handed to the codec
//   UNDERRUN_CNT_W : width of the saturating underrun counter
// ---------------------------------------------------------------------------
package i2s_pkg;

  typedef enum logic [1:0] {
    FIFO_IDLE,
    FIFO_PRIME,
    FIFO_RUN
  } fifo_state_t;

  localparam int I2S_WORD_W     = 32;
  localparam int UNDERRUN_CNT_W = 16;

endpackage : i2s_pkg

// File: rtl/i2s_sample_ram.sv
// ---------------------------------------------------------------------------
// i2s_sample_ram
//   DEPTH x DATA_WIDTH sample storage, synchronous write, asynchronous read.
//   clk        in   write clock
//   i_wr_en    in   write strobe
//   i_wr_addr  in   write index
//   i_wr_data  in   sample to store
//   i_rd_addr  in   read index
//   o_rd_data  out  sample at i_rd_addr (combinational)
// ---------------------------------------------------------------------------
module i2s_sample_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
  input  logic [DATA_WIDTH-1:0]      i_wr_data,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
  output logic [DATA_WIDTH-1:0]      o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage is deliberately not reset; only the pointers define which
  // entries are valid, and a resettable array would not map onto RAM cells.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule : i2s_sample_ram

// File: rtl/i2s_tx_sample_fifo.sv
// ---------------------------------------------------------------------------
// i2s_tx_sample_fifo
//   Circular sample buffer feeding the I2S transmitter. Samples arrive over
//   valid/ready; one sample is presented on i2din per codec buffer strobe.
//   Output is withheld (zeros) until PRIME_LEVEL samples are stored, and an
//   empty strobe while running is counted as an underrun.
//   sysclk        in   system clock
//   reset         in   async active-low reset
//   enabler       in   block enable; low flushes to IDLE on the next edge
//   wr_valid      in   source sample valid
//   wr_data       in   source sample
//   wr_ready      out  FIFO can accept wr_data this cycle
//   buffer        in   codec read strobe
//   i2din         out  served sample, zero-extended, 1 cycle after strobe
//   level         out  stored entries 0..DEPTH
//   empty / full  out  level==0 / level==DEPTH
//   underrun_cnt  out  saturating count of underrun strobes
//   clr_underrun  in   synchronous clear of underrun_cnt
// ---------------------------------------------------------------------------
module i2s_tx_sample_fifo
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 16,
  parameter int PRIME_LEVEL = 4,
  parameter int REPRIME     = 1
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic                        enabler,
  input  logic                        wr_valid,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic                        wr_ready,
  input  logic                        buffer,
  output logic [I2S_WORD_W-1:0]       i2din,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        empty,
  output logic                        full,
  output logic [UNDERRUN_CNT_W-1:0]   underrun_cnt,
  input  logic                        clr_underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [UNDERRUN_CNT_W-1:0] CNT_MAX = '1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]               r_wr_ptr;
  logic [PW-1:0]               r_rd_ptr;
  fifo_state_t                 r_state;
  logic [I2S_WORD_W-1:0]       r_i2din;
  logic [UNDERRUN_CNT_W-1:0]   r_underrun_cnt;

  logic [PW-1:0]               w_level;
  logic                        w_empty;
  logic                        w_full;
  logic                        w_wr_ready;
  logic                        w_wr_en;
  logic                        w_run_strobe;
  logic                        w_serve;
  logic                        w_underrun;
  logic [DATA_WIDTH-1:0]       w_rd_data;

  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Held low while reset is asserted so the source never sees ready in reset.
  assign w_wr_ready = reset && enabler && !w_full;
  assign w_wr_en    = wr_valid && w_wr_ready;

  // No bypass: a strobe on an empty FIFO underruns even if a write lands now.
  assign w_run_strobe = enabler && buffer && (r_state == FIFO_RUN);
  assign w_serve      = w_run_strobe && !w_empty;
  assign w_underrun   = w_run_strobe && w_empty;

  i2s_sample_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk        (sysclk),
    .i_wr_en    (w_wr_en),
    .i_wr_addr  (r_wr_ptr[AW-1:0]),
    .i_wr_data  (wr_data),
    .i_rd_addr  (r_rd_ptr[AW-1:0]),
    .o_rd_data  (w_rd_data)
  );

  // Pointers and output word.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_i2din  <= '0;
    end else if (!enabler) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_i2din  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (buffer) begin
        if (w_serve) begin
          r_i2din  <= I2S_WORD_W'(w_rd_data);
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end else begin
          r_i2din  <= '0;
        end
      end
    end
  end

  // Serving state. PRIME->RUN looks at the registered level, so a strobe in
  // the transition cycle is still treated as PRIME.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state <= FIFO_IDLE;
    end else if (!enabler) begin
      r_state <= FIFO_IDLE;
    end else begin
      case (r_state)
        FIFO_IDLE: begin
          r_state <= FIFO_PRIME;
        end
        FIFO_PRIME: begin
          if (w_level >= PW'(PRIME_LEVEL)) begin
            r_state <= FIFO_RUN;
          end
        end
        FIFO_RUN: begin
          if (w_underrun && (REPRIME != 0)) begin
            r_state <= FIFO_PRIME;
          end
        end
        default: begin
          r_state <= FIFO_IDLE;
        end
      endcase
    end
  end

  // Underrun counter: held across flushes, clear beats increment.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_underrun_cnt <= '0;
    end else if (clr_underrun) begin
      r_underrun_cnt <= '0;
    end else if (w_underrun && (r_underrun_cnt != CNT_MAX)) begin
      r_underrun_cnt <= r_underrun_cnt + UNDERRUN_CNT_W'(1);
    end
  end

  assign wr_ready     = w_wr_ready;
  assign i2din        = r_i2din;
  assign level        = w_level;
  assign empty        = w_empty;
  assign full         = w_full;
  assign underrun_cnt = r_underrun_cnt;

endmodule : i2s_tx_sample_fifo

// File: tb/tb_i2s_tx_sample_fifo.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx_sample_fifo
//   Directed bench for i2s_tx_sample_fifo. Two instances share one stimulus:
//   u_dut_a re-primes after an underrun, u_dut_b stays in RUN.
// ---------------------------------------------------------------------------
module tb_i2s_tx_sample_fifo;

  logic        sysclk;
  logic        reset;
  logic        enabler;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        buffer;
  logic        clr_underrun;

  logic        a_wr_ready, b_wr_ready;
  logic [31:0] a_i2din,    b_i2din;
  logic [4:0]  a_level,    b_level;
  logic        a_empty,    b_empty;
  logic        a_full,     b_full;
  logic [15:0] a_cnt,      b_cnt;

  int n_tests;
  int n_fail;

  i2s_tx_sample_fifo #(
    .DATA_WIDTH (16), .DEPTH (16), .PRIME_LEVEL (4), .REPRIME (1)
  ) u_dut_a (
    .sysclk (sysclk), .reset (reset), .enabler (enabler),
    .wr_valid (wr_valid), .wr_data (wr_data), .wr_ready (a_wr_ready),
    .buffer (buffer), .i2din (a_i2din), .level (a_level),
    .empty (a_empty), .full (a_full), .underrun_cnt (a_cnt),
    .clr_underrun (clr_underrun)
  );

  i2s_tx_sample_fifo #(
    .DATA_WIDTH (16), .DEPTH (16), .PRIME_LEVEL (4), .REPRIME (0)
  ) u_dut_b (
    .sysclk (sysclk), .reset (reset), .enabler (enabler),
    .wr_valid (wr_valid), .wr_data (wr_data), .wr_ready (b_wr_ready),
    .buffer (buffer), .i2din (b_i2din), .level (b_level),
    .empty (b_empty), .full (b_full), .underrun_cnt (b_cnt),
    .clr_underrun (clr_underrun)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic strobe();
    buffer = 1'b1;
    tick();
    buffer = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    enabler      = 1'b0;
    wr_valid     = 1'b0;
    wr_data      = '0;
    buffer       = 1'b0;
    clr_underrun = 1'b0;
    tick();
    tick();
    reset   = 1'b1;
    enabler = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // ---- 1: asynchronous reset mid-stream ----
    do_reset();
    for (int i = 1; i <= 5; i++) push(16'hA000 + 16'(i));
    strobe();
    push(16'hA006);
    check("t1_pre_level", 32'(a_level), 32'd5);
    check("t1_pre_i2din", a_i2din, 32'h0000_A001);
    #2 reset = 1'b0;
    #1;
    check("t1_rst_level", 32'(a_level), 32'd0);
    check("t1_rst_i2din", a_i2din, 32'd0);
    check("t1_rst_empty", 32'(a_empty), 32'd1);
    check("t1_rst_full", 32'(a_full), 32'd0);
    check("t1_rst_ready", 32'(a_wr_ready), 32'd0);
    check("t1_rst_cnt", 32'(a_cnt), 32'd0);

    // ---- 2: priming ----
    do_reset();
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    strobe();
    check("t2_prime_i2din", a_i2din, 32'd0);
    check("t2_prime_cnt", 32'(a_cnt), 32'd0);
    check("t2_prime_level", 32'(a_level), 32'd3);
    push(16'h4444);
    check("t2_level4", 32'(a_level), 32'd4);
    strobe();  // transition cycle: still PRIME
    check("t2_trans_i2din", a_i2din, 32'd0);
    check("t2_trans_level", 32'(a_level), 32'd4);
    strobe();
    check("t2_run_i2din", a_i2din, 32'h0000_1111);
    check("t2_run_level", 32'(a_level), 32'd3);
    tick();
    check("t2_hold_i2din", a_i2din, 32'h0000_1111);

    // ---- 3: full and pointer wrap ----
    do_reset();
    for (int i = 0; i < 16; i++) push(16'h3000 + 16'(i));
    wr_valid = 1'b1;
    wr_data  = 16'h3010;
    check("t3_full_ready", 32'(a_wr_ready), 32'd0);
    check("t3_full_level", 32'(a_level), 32'd16);
    check("t3_full_flag", 32'(a_full), 32'd1);
    tick();
    check("t3_full_stuck", 32'(a_level), 32'd16);
    buffer = 1'b1;
    tick();
    buffer = 1'b0;
    check("t3_freed_ready", 32'(a_wr_ready), 32'd1);
    check("t3_freed_i2din", a_i2din, 32'h0000_3000);
    check("t3_freed_level", 32'(a_level), 32'd15);
    tick();
    wr_valid = 1'b0;
    check("t3_17th_level", 32'(a_level), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      strobe();
      check($sformatf("t3_drain%0d", i), a_i2din, 32'h3000 + 32'(i));
    end
    check("t3_empty", 32'(a_empty), 32'd1);

    // ---- 4: underrun, re-prime vs stay in RUN ----
    strobe();
    check("t4_ur_i2din", a_i2din, 32'd0);
    check("t4_ur_cnt_a", 32'(a_cnt), 32'd1);
    check("t4_ur_cnt_b", 32'(b_cnt), 32'd1);
    check("t4_ur_level", 32'(a_level), 32'd0);
    push(16'h4A01);
    tick();
    strobe();
    check("t4_reprime_i2din", a_i2din, 32'd0);
    check("t4_reprime_cnt", 32'(a_cnt), 32'd1);
    check("t4_reprime_level", 32'(a_level), 32'd1);
    check("t4_norep_i2din", b_i2din, 32'h0000_4A01);
    check("t4_norep_level", 32'(b_level), 32'd0);
    check("t4_norep_cnt", 32'(b_cnt), 32'd1);

    // ---- 5: simultaneous write and read ----
    do_reset();
    for (int i = 1; i <= 4; i++) push(16'h5000 + 16'(i));
    tick();
    for (int i = 1; i <= 3; i++) begin
      strobe();
      check($sformatf("t5_serve%0d", i), a_i2din, 32'h5000 + 32'(i));
    end
    check("t5_level1", 32'(a_level), 32'd1);
    wr_valid = 1'b1;
    wr_data  = 16'hBEEF;
    buffer   = 1'b1;
    tick();
    wr_valid = 1'b0;
    buffer   = 1'b0;
    check("t5_sim_i2din", a_i2din, 32'h0000_5004);
    check("t5_sim_level", 32'(a_level), 32'd1);
    strobe();
    check("t5_beef", a_i2din, 32'h0000_BEEF);
    check("t5_beef_level", 32'(a_level), 32'd0);
    wr_valid = 1'b1;
    wr_data  = 16'h5555;
    buffer   = 1'b1;
    tick();
    wr_valid = 1'b0;
    buffer   = 1'b0;
    check("t5_ur_i2din", a_i2din, 32'd0);
    check("t5_ur_cnt_a", 32'(a_cnt), 32'd1);
    check("t5_ur_level_a", 32'(a_level), 32'd1);
    check("t5_ur_cnt_b", 32'(b_cnt), 32'd1);
    check("t5_ur_level_b", 32'(b_level), 32'd1);
    strobe();
    check("t5_after_b", b_i2din, 32'h0000_5555);
    check("t5_after_a", a_i2din, 32'd0);

    // ---- 6: saturation, clear priority, flush ----
    do_reset();
    for (int i = 1; i <= 4; i++) push(16'h6000 + 16'(i));
    tick();
    for (int i = 0; i < 4; i++) strobe();
    check("t6_drained", a_i2din, 32'h0000_6004);
    buffer = 1'b1;
    repeat (65534) @(posedge sysclk);
    #1;
    check("t6_cnt_fffe", 32'(b_cnt), 32'h0000_FFFE);
    tick();
    check("t6_cnt_ffff", 32'(b_cnt), 32'h0000_FFFF);
    tick();
    check("t6_cnt_sat", 32'(b_cnt), 32'h0000_FFFF);
    check("t6_cnt_a", 32'(a_cnt), 32'd1);
    check("t6_ur_i2din", b_i2din, 32'd0);
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    check("t6_clr_wins", 32'(b_cnt), 32'd0);
    tick();
    buffer = 1'b0;
    check("t6_recount", 32'(b_cnt), 32'd1);
    for (int i = 1; i <= 8; i++) push(16'h6100 + 16'(i));
    strobe();
    check("t6_pre_i2din", b_i2din, 32'h0000_6101);
    check("t6_pre_level", 32'(b_level), 32'd7);
    check("t6_pre_level_a", 32'(a_level), 32'd7);
    enabler = 1'b0;
    #1;
    check("t6_dis_ready", 32'(b_wr_ready), 32'd0);
    tick();
    check("t6_flush_level", 32'(b_level), 32'd0);
    check("t6_flush_empty", 32'(b_empty), 32'd1);
    check("t6_flush_i2din", b_i2din, 32'd0);
    check("t6_flush_cnt", 32'(b_cnt), 32'd1);
    check("t6_flush_cnt_a", 32'(a_cnt), 32'd0);
    enabler = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_i2s_tx_sample_fifo
